// File: rtl/ram_block_if.sv
// Memory bus between the CPU bus decoder (master) and ram_block (slave).
// Carries the req/ready handshake, the zero-fill command and the read/status strobes.
interface ram_block_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  logic                  req;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  clear;
  logic                  ready;
  logic                  busy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  error;

  modport master (
    output req, write_enable, address, data_in, clear,
    input  ready, busy, data_out, data_valid, error
  );

  modport slave (
    input  req, write_enable, address, data_in, clear,
    output ready, busy, data_out, data_valid, error
  );
endinterface

// File: rtl/ram_block.sv
// Parametrised single-port on-chip RAM for the 8008 soft processor.
// Registered reads with a valid strobe, out-of-range flagging, and a
// zero-fill sequencer that runs after reset (optional) or on command.
module ram_block #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 9,
  parameter int DEPTH          = 512,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic         clk,
  input logic         reset_n,
  ram_block_if.slave  bus
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Index width covers the implemented words only; DEPTH <= 2**ADDR_WIDTH
  // guarantees IDX_W <= ADDR_WIDTH.
  localparam int                  IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam state_t              RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable and the
  // range check is then always true.
  localparam logic [ADDR_WIDTH:0] DEPTH_CMP   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(DEPTH - 1);

  // Storage is deliberately not reset so it maps onto block RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      clear_addr_q, clear_addr_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q, data_valid_d;
  logic                  error_q, error_d;

  logic                  in_range;
  logic [IDX_W-1:0]      acc_idx;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_en;

  assign in_range = ({1'b0, bus.address} < DEPTH_CMP);
  assign acc_idx  = bus.address[IDX_W-1:0];

  // Next-state, single write-port arbitration and strobe generation.
  // In IDLE a clear request takes priority and the same-cycle req is dropped.
  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    data_valid_d = 1'b0;
    error_d      = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = clear_addr_q;
    mem_wdata    = '0;
    rd_en        = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        if (clear_addr_q == LAST_IDX) begin
          state_d      = ST_IDLE;
          clear_addr_d = '0;
        end else begin
          clear_addr_d = clear_addr_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (bus.clear) begin
          state_d = ST_CLEAR;
        end else if (bus.req) begin
          if (bus.write_enable) begin
            if (in_range) begin
              mem_we    = 1'b1;
              mem_waddr = acc_idx;
              mem_wdata = bus.data_in;
            end else begin
              error_d = 1'b1;
            end
          end else begin
            rd_en        = 1'b1;
            data_valid_d = 1'b1;
            error_d      = !in_range;
          end
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // Control registers; asynchronous reset drops any pending strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RESET_STATE;
      clear_addr_q <= '0;
      data_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      data_valid_q <= data_valid_d;
      error_q      <= error_d;
    end
  end

  // Read data register: updated only by an accepted read, held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= '0;
    end else if (rd_en) begin
      data_out_q <= in_range ? mem[acc_idx] : '0;
    end
  end

  // Single write port shared by the fill sequencer and bus writes; held off during reset.
  always_ff @(posedge clk) begin
    if (mem_we && reset_n) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.ready      = (state_q == ST_IDLE);
  assign bus.busy       = (state_q == ST_CLEAR);
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_ram_block.sv
// Scoreboard bench for ram_block with DEPTH=300, ADDR_WIDTH=9, CLEAR_ON_RESET=1.
module tb_ram_block;
  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int DEPTH = 300;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_block_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_block #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    logic          is_read;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model [DEPTH];
  int            vectors_applied = 0;
  int            miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output side of the scoreboard: every strobe must match the oldest expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset_n && (bus.data_valid || bus.error)) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_strobe", 32'({bus.data_valid, bus.error}), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check_val("data_valid", 32'(bus.data_valid), 32'(mon_e.is_read));
        check_val("error", 32'(bus.error), 32'(mon_e.err));
        if (mon_e.is_read) check_val("rdata", 32'(bus.data_out), 32'(mon_e.data));
        $display("%s addr=0x%03h data_out=0x%02h exp=0x%02h dv=%0b err=%0b",
                 mon_e.is_read ? "RD" : "WR", mon_e.addr, bus.data_out,
                 mon_e.data, bus.data_valid, bus.error);
      end
    end
  end

  // Called at posedge+1 with the block idle; issues one accepted transfer.
  task automatic access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    exp_t e;
    check_val("ready_at_req", 32'(bus.ready), 32'(1));
    bus.req = 1'b1; bus.write_enable = we; bus.address = addr; bus.data_in = d;
    @(posedge clk);
    e.is_read = !we;
    e.addr    = addr;
    e.err     = (32'(addr) >= DEPTH);
    e.data    = '0;
    if (we) begin
      if (!e.err) model[addr] = d;
      else exp_q.push_back(e);
    end else begin
      if (!e.err) e.data = model[addr];
      exp_q.push_back(e);
    end
    #1;
    bus.req = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int expect_edges);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check_val(tag, 32'(n), 32'(expect_edges));
    check_val({tag, "_busy_low"}, 32'(bus.busy), 32'(0));
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
    check_val("queue_drained", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic hold_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check_val({tag, "_busy"}, 32'(bus.busy), 32'(1));
    check_val({tag, "_ready"}, 32'(bus.ready), 32'(0));
    check_val({tag, "_dv"}, 32'(bus.data_valid), 32'(0));
    check_val({tag, "_err"}, 32'(bus.error), 32'(0));
    check_val({tag, "_dout"}, 32'(bus.data_out), 32'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_val({tag, "_busy_held"}, 32'(bus.busy), 32'(1));
    check_val({tag, "_dv_held"}, 32'(bus.data_valid), 32'(0));
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req = 1'b0; bus.write_enable = 1'b0; bus.address = '0;
    bus.data_in = '0; bus.clear = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset state and power-up fill
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(bus.busy), 32'(1));
    check_val("rst_ready", 32'(bus.ready), 32'(0));
    check_val("rst_dv", 32'(bus.data_valid), 32'(0));
    check_val("rst_err", 32'(bus.error), 32'(0));
    check_val("rst_dout", 32'(bus.data_out), 32'(0));
    reset_n = 1'b1;
    wait_ready("fill_after_reset", DEPTH);
    access(1'b0, 9'd299, 8'h00);
    drain();

    // Write then read on the next cycle, and data_out hold
    access(1'b1, 9'h010, 8'hA5);
    access(1'b0, 9'h010, 8'h00);
    drain();
    check_val("dout_hold", 32'(bus.data_out), 32'(8'hA5));

    // Back-to-back writes then reads
    access(1'b1, 9'h000, 8'h11);
    access(1'b1, 9'h001, 8'h22);
    access(1'b1, 9'h002, 8'h33);
    access(1'b1, 9'h003, 8'h44);
    for (int i = 0; i < 4; i++) access(1'b0, AW'(i), 8'h00);
    drain();

    // Out-of-range accesses, then full scan showing storage untouched
    access(1'b1, 9'h12C, 8'h55);
    access(1'b0, 9'h12C, 8'h00);
    access(1'b0, 9'h1FF, 8'h00);
    for (int i = 0; i < DEPTH; i++) access(1'b0, AW'(i), 8'h00);
    drain();

    // clear together with req: request ignored, fill takes DEPTH edges
    access(1'b1, 9'h005, 8'hFF);
    bus.clear = 1'b1; bus.req = 1'b1; bus.write_enable = 1'b0; bus.address = 9'h005;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.req = 1'b0;
    check_val("clear_ready_low", 32'(bus.ready), 32'(0));
    wait_ready("fill_on_clear", DEPTH);
    access(1'b0, 9'h005, 8'h00);
    access(1'b0, 9'h010, 8'h00);
    drain();

    // Reset while a read strobe is pending
    access(1'b1, 9'h020, 8'h3C);
    access(1'b0, 9'h020, 8'h00);
    check_val("dv_before_reset", 32'(bus.data_valid), 32'(1));
    hold_reset("rst_mid_read");
    wait_ready("fill_after_read_reset", DEPTH);
    access(1'b0, 9'h020, 8'h00);
    drain();

    // Reset at clear_addr=150: fill restarts from 0
    access(1'b1, 9'd299, 8'h99);
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    hold_reset("rst_mid_clear");
    wait_ready("fill_after_clear_reset", DEPTH);
    access(1'b0, 9'd299, 8'h00);
    access(1'b0, 9'd0, 8'h00);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end
endmodule
